// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  localparam int unsigned SEG_W = 7;

  // Active-low patterns, bit 6 = segment a ... bit 0 = segment g
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display register side of the scan driver: hex word, masks, load strobe and pin outputs.
interface seg7_scan_driver_if #(
  parameter int unsigned N_DIGITS = 8
);

  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   dig_en;
  logic                  lz_blank;
  logic                  load;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_done;

  modport master (
    output value, dp_in, dig_en, lz_blank, load,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value, dp_in, dig_en, lz_blank, load,
    output seg, dp, an, frame_done
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern, output polarity selectable.
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]       i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_TABLE[i_nibble];
    if (!ACTIVE_LOW) o_seg_c = ~SEG_TABLE[i_nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered display data,
// blanking gaps between digits and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 8,
  parameter int unsigned ON_CYCLES      = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned IDX_W   = $clog2(N_DIGITS);
  localparam int unsigned VAL_W   = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0]    ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [SEG_W-1:0]    SEG_DARK   = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic                DP_DARK    = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_DARK    = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  state_e               r_state,     w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx,       w_idx_nxt;
  logic                 w_wrap;

  logic [VAL_W-1:0]     r_stg_value, w_stg_value_nxt;
  logic [N_DIGITS-1:0]  r_stg_dp,    w_stg_dp_nxt;
  logic [N_DIGITS-1:0]  r_stg_en,    w_stg_en_nxt;
  logic                 r_stg_lz,    w_stg_lz_nxt;
  logic                 r_pending,   w_pending_nxt;

  logic [VAL_W-1:0]     r_shd_value, w_shd_value_nxt;
  logic [N_DIGITS-1:0]  r_shd_dp,    w_shd_dp_nxt;
  logic [N_DIGITS-1:0]  r_shd_en,    w_shd_en_nxt;
  logic                 r_shd_lz,    w_shd_lz_nxt;

  logic [SEG_W-1:0]     r_seg,       w_seg_nxt;
  logic                 r_dp,        w_dp_nxt;
  logic [N_DIGITS-1:0]  r_an,        w_an_nxt;
  logic                 r_frame_done, w_frame_done_nxt;

  logic [3:0]           w_nib;
  logic [SEG_W-1:0]     w_dec_seg;
  logic [N_DIGITS-1:0]  w_upper_zero;
  logic [N_DIGITS-1:0]  w_onehot;
  logic                 w_lit;

  // Scan sequencing and staging/shadow buffer updates
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_idx_nxt       = r_idx;
    w_wrap          = 1'b0;
    w_stg_value_nxt = r_stg_value;
    w_stg_dp_nxt    = r_stg_dp;
    w_stg_en_nxt    = r_stg_en;
    w_stg_lz_nxt    = r_stg_lz;
    w_pending_nxt   = r_pending;
    w_shd_value_nxt = r_shd_value;
    w_shd_dp_nxt    = r_shd_dp;
    w_shd_en_nxt    = r_shd_en;
    w_shd_lz_nxt    = r_shd_lz;

    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = '0;
        end
      end
      ST_ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase

    if (bus.load) begin
      w_stg_value_nxt = bus.value;
      w_stg_dp_nxt    = bus.dp_in;
      w_stg_en_nxt    = bus.dig_en;
      w_stg_lz_nxt    = bus.lz_blank;
    end

    // A load landing on the wrap edge bypasses staging so it is not a frame late
    if (w_wrap && bus.load) begin
      w_shd_value_nxt = bus.value;
      w_shd_dp_nxt    = bus.dp_in;
      w_shd_en_nxt    = bus.dig_en;
      w_shd_lz_nxt    = bus.lz_blank;
      w_pending_nxt   = 1'b0;
    end else if (bus.load) begin
      w_pending_nxt   = 1'b1;
    end else if (w_wrap && r_pending) begin
      w_shd_value_nxt = r_stg_value;
      w_shd_dp_nxt    = r_stg_dp;
      w_shd_en_nxt    = r_stg_en;
      w_shd_lz_nxt    = r_stg_lz;
      w_pending_nxt   = 1'b0;
    end
  end

  assign w_nib    = w_shd_value_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_onehot = N_DIGITS'(1) << w_idx_nxt;

  seg7_hex_decode #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .i_nibble (w_nib),
    .o_seg_c  (w_dec_seg)
  );

  // Pin values for the upcoming cycle; registered below alongside the state
  always_comb begin
    logic run;
    run          = 1'b1;
    w_upper_zero = '0;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      run             = run && (w_shd_value_nxt[4*i +: 4] == 4'h0);
      w_upper_zero[i] = run;
    end

    w_lit = (w_state_nxt == ST_ON) && w_shd_en_nxt[w_idx_nxt] &&
            !(w_shd_lz_nxt && (w_idx_nxt != '0) && w_upper_zero[w_idx_nxt]);

    w_an_nxt  = AN_DARK;
    w_seg_nxt = SEG_DARK;
    w_dp_nxt  = DP_DARK;
    if (w_lit) begin
      w_an_nxt  = AN_DARK ^ w_onehot;
      w_seg_nxt = w_dec_seg;
      w_dp_nxt  = w_shd_dp_nxt[w_idx_nxt] ? ~DP_DARK : DP_DARK;
    end

    w_frame_done_nxt = (w_state_nxt == ST_ON) && (w_idx_nxt == IDX_LAST) &&
                       (w_cnt_nxt == ON_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_stg_value  <= '0;
      r_stg_dp     <= '0;
      r_stg_en     <= '0;
      r_stg_lz     <= 1'b0;
      r_pending    <= 1'b0;
      r_shd_value  <= '0;
      r_shd_dp     <= '0;
      r_shd_en     <= '0;
      r_shd_lz     <= 1'b0;
      r_seg        <= SEG_DARK;
      r_dp         <= DP_DARK;
      r_an         <= AN_DARK;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_stg_value  <= w_stg_value_nxt;
      r_stg_dp     <= w_stg_dp_nxt;
      r_stg_en     <= w_stg_en_nxt;
      r_stg_lz     <= w_stg_lz_nxt;
      r_pending    <= w_pending_nxt;
      r_shd_value  <= w_shd_value_nxt;
      r_shd_dp     <= w_shd_dp_nxt;
      r_shd_en     <= w_shd_en_nxt;
      r_shd_lz     <= w_shd_lz_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.an         = r_an;
  assign bus.frame_done = r_frame_done;

endmodule
